id_stage_pipelined: RTL and testbench
=====================================

Name: id_stage_pipelined

Overview:
Parametrised decode stage for the 16-bit pipelined CPU. It owns the IF/ID pipeline register (valid/stall/flush), the register file with write-through bypass, and the Z/V/N flag register. It contains load-use and flag-use hazard detection and resolves B/BR in ID. It also latches HLT. It sits between fetch and the ID/EX register and drives fetch's PC select and stall.

Parameters:
DATA_W, 16, datapath/PC width
REG_AW, 4, register address width; 2^REG_AW registers, register 0 reads as 0
IMM_W, 9, branch immediate width (instr[IMM_W-1:0])
BR_SHIFT, 1, left shift applied to sign-extended branch immediate

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
if_valid  in  1  fetch presents a valid instruction
if_instr  in  16  fetched instruction
if_pc_next  in  DATA_W  PC of fetched instruction + increment
ex_valid  in  1  ID/EX holds a valid instruction
ex_mem_read  in  1  EX instruction is LW
ex_sets_flags  in  1  EX instruction writes any flag
ex_dst  in  REG_AW  EX destination register
flag_we  in  3  per-flag write enable {Z,V,N} from EX
flag_in  in  3  new {Z,V,N}
wb_we  in  1  writeback enable
wb_dst  in  REG_AW  writeback register
wb_data  in  DATA_W  writeback data
stall  out  1  hold PC and IF/ID
pc_sel  out  1  take branch target
pc_target  out  DATA_W  branch target
halted  out  1  sticky halt
id_valid  out  1  decoded instruction valid for ID/EX (0 = bubble)
id_opcode  out  4  instr[15:12]
id_dst  out  REG_AW  destination register
id_rdata1, id_rdata2  out  DATA_W  operands
id_imm  out  DATA_W  sign-extended immediate
id_pc_next  out  DATA_W  latched PC+increment (for PCS)

Behaviour:
- Clock is clk. Reset rst_n is synchronous and active-low. All state updates on the rising edge.
- Reset: IF/ID valid=0, instr=0, pc=0; flags=000; halted=0; all registers=0. Consequently stall=0, pc_sel=0, id_valid=0.
- IF/ID update priority: reset > halted (hold) > flush (valid<=0) > stall (hold) > capture {if_valid, if_instr, if_pc_next}.
- flush = pc_sel. The wrong-path instruction in fetch is discarded, which costs one bubble.
- Decode: opcodes come from the shared package. Source use per class:
  - compute: rs=instr[7:4], rt=instr[3:0]
  - LW/SW: base=instr[7:4]; SW also reads instr[11:8]
  - LLB/LHB: read instr[11:8]
  - BR: reads instr[7:4]
  - B/PCS/HLT: no operand reads except as listed
- Load-use stall: ex_valid & ex_mem_read & ex_dst!=0 & a used source equals ex_dst.
- Flag-use stall: valid B or BR in ID & ex_valid & ex_sets_flags.
- stall = ID valid & ~halted & (load-use | flag-use). During a stall: id_valid=0, pc_sel=0.
- Branch: condition instr[11:9] is evaluated against the flag register (codes per package).
  - pc_sel = valid & ~stall & ~halted & (B|BR) & condition true. The output is combinational in the same cycle.
  - B target = pc_next + (sext(instr[IMM_W-1:0]) << BR_SHIFT), computed modulo 2^DATA_W.
  - BR target = rdata1.
- Flags: each bit is written only when its flag_we bit is set. A flag write and a branch read in the same cycle cannot collide because the flag-use stall prevents it.
- Register file:
  - Synchronous write when wb_we & wb_dst!=0.
  - Writes to register 0 are ignored.
  - Same-cycle read of wb_dst returns wb_data (write-through bypass).
- HLT: when valid & ~stall is seen in ID, halted<=1 next edge. The HLT itself still passes with id_valid=1. Afterwards id_valid=0 and IF/ID is frozen until reset.
- Reset asserted mid-stall or mid-branch: all state clears at that edge. No pending flush survives.
- id_dst: instr[11:8]. id_imm: sign-extended instr[IMM_W-1:0] for branches; instr[7:0] zero-extended for LLB/LHB; sext(instr[3:0]) for LW/SW.

Decomposition:
- Shared package cpu_pkg: opcode constants, branch condition codes (NE, EQ, GT, LT, GE, LE, OVF, UNCOND), flag bit indices Z/V/N.
- One sub-module, id_hazard_unit: source-use decode plus load-use/flag-use stall equations. It is combinational and verified standalone.

Test Plan:
- Write R3=0x1234 via WB while the ID instruction reads R3 in the same cycle -> id_rdata1=0x1234; a WB to R0 with 0xFFFF -> R0 reads 0.
- EX holds LW R5, ID holds ADD R6,R5,R1 -> stall=1 for one cycle, id_valid=0; the next cycle id_valid=1 and IF/ID unchanged.
- Flags Z=1, ID holds B EQ with pc_next=0x0010, imm=0x1FC (-4) -> pc_sel=1, pc_target=0x0008; the following cycle id_valid=0 (flushed).
- EX sets flags while ID holds B -> one stall cycle. After flag_we=3'b100, flag_in=3'b000 (Z=0) the branch EQ is not taken.
- HLT in ID -> halted=1 the next edge. Subsequent if_valid instructions are ignored. rst_n=0 clears halted.
- Assert rst_n=0 during an active stall -> the next edge has stall=0, id_valid=0, flags=000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU: opcodes, branch conditions,
// flag bit positions and the branch-condition evaluator.
package cpu_pkg;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LLB    = 4'hA;
    localparam logic [3:0] OP_LHB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    typedef enum logic [2:0] {
        COND_NE     = 3'd0,
        COND_EQ     = 3'd1,
        COND_GT     = 3'd2,
        COND_LT     = 3'd3,
        COND_GE     = 3'd4,
        COND_LE     = 3'd5,
        COND_OVF    = 3'd6,
        COND_UNCOND = 3'd7
    } cond_e;

    // Flag register layout is {Z,V,N}
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    function automatic logic condTrue(input logic [2:0] cond, input logic [2:0] flags);
        logic z;
        logic v;
        logic n;
        logic result;
        z = flags[FLAG_Z];
        v = flags[FLAG_V];
        n = flags[FLAG_N];
        case (cond_e'(cond))
            COND_NE:  result = ~z;
            COND_EQ:  result = z;
            COND_GT:  result = ~z & ~n;
            COND_LT:  result = n;
            COND_GE:  result = z | ~n;
            COND_LE:  result = z | n;
            COND_OVF: result = v;
            default:  result = 1'b1;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/id_hazard_unit.sv
// Source-register decode and load-use / flag-use stall detection for the ID stage.
// Purely combinational.
module id_hazard_unit
    import cpu_pkg::*;
#(
    parameter int REG_AW = 4
) (
    input  logic              idValid,
    input  logic              halted,
    input  logic [15:0]       instr,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_sets_flags,
    input  logic [REG_AW-1:0] ex_dst,
    output logic [REG_AW-1:0] rs1,
    output logic [REG_AW-1:0] rs2,
    output logic              stall
);

    logic [3:0] opcode;
    logic       use1;
    logic       use2;
    logic       isBranch;
    logic       loadUse;
    logic       flagUse;

    assign opcode = instr[15:12];

    // Port 1 carries rs/base (or the LLB/LHB target), port 2 carries rt or SW data.
    always_comb begin
        use1 = 1'b0;
        use2 = 1'b0;
        rs1  = REG_AW'(instr[7:4]);
        rs2  = REG_AW'(instr[3:0]);
        if (!opcode[3]) begin
            use1 = 1'b1;
            use2 = 1'b1;
        end else begin
            case (opcode)
                OP_LW: use1 = 1'b1;
                OP_SW: begin
                    use1 = 1'b1;
                    use2 = 1'b1;
                    rs2  = REG_AW'(instr[11:8]);
                end
                OP_LLB, OP_LHB: begin
                    use1 = 1'b1;
                    rs1  = REG_AW'(instr[11:8]);
                end
                OP_BR:   use1 = 1'b1;
                default: ;
            endcase
        end
    end

    assign isBranch = (opcode == OP_B) | (opcode == OP_BR);
    assign loadUse  = ex_valid & ex_mem_read & (ex_dst != '0) &
                      ((use1 & (rs1 == ex_dst)) | (use2 & (rs2 == ex_dst)));
    assign flagUse  = isBranch & ex_valid & ex_sets_flags;
    assign stall    = idValid & ~halted & (loadUse | flagUse);

endmodule

// File: rtl/id_stage_pipelined.sv
// Decode stage: IF/ID register, bypassed register file, flag register, hazard
// stalls, branch resolution and sticky halt.
module id_stage_pipelined
    import cpu_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 4,
    parameter int IMM_W    = 9,
    parameter int BR_SHIFT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    input  logic [15:0]       if_instr,
    input  logic [DATA_W-1:0] if_pc_next,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_sets_flags,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic [2:0]        flag_we,
    input  logic [2:0]        flag_in,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_dst,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              pc_sel,
    output logic [DATA_W-1:0] pc_target,
    output logic              halted,
    output logic              id_valid,
    output logic [3:0]        id_opcode,
    output logic [REG_AW-1:0] id_dst,
    output logic [DATA_W-1:0] id_rdata1,
    output logic [DATA_W-1:0] id_rdata2,
    output logic [DATA_W-1:0] id_imm,
    output logic [DATA_W-1:0] id_pc_next
);

    localparam int NUM_REGS = 2 ** REG_AW;

    logic              validReg;
    logic [15:0]       instrReg;
    logic [DATA_W-1:0] pcReg;
    logic [2:0]        flagsReg;
    logic              haltedReg;
    logic [DATA_W-1:0] regs [1:NUM_REGS-1];

    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [3:0]        opcode;
    logic              isB;
    logic              isBR;
    logic [DATA_W-1:0] immBranch;
    logic [DATA_W-1:0] branchOffset;

    id_hazard_unit #(
        .REG_AW(REG_AW)
    ) hazardUnit (
        .idValid      (validReg),
        .halted       (haltedReg),
        .instr        (instrReg),
        .ex_valid     (ex_valid),
        .ex_mem_read  (ex_mem_read),
        .ex_sets_flags(ex_sets_flags),
        .ex_dst       (ex_dst),
        .rs1          (rs1),
        .rs2          (rs2),
        .stall        (stall)
    );

    // Register 0 has no storage; a same-cycle writeback is forwarded to the reader.
    assign id_rdata1 = (rs1 == '0) ? '0 :
                       (wb_we && wb_dst == rs1) ? wb_data : regs[rs1];
    assign id_rdata2 = (rs2 == '0) ? '0 :
                       (wb_we && wb_dst == rs2) ? wb_data : regs[rs2];

    assign opcode       = instrReg[15:12];
    assign isB          = (opcode == OP_B);
    assign isBR         = (opcode == OP_BR);
    assign immBranch    = {{(DATA_W-IMM_W){instrReg[IMM_W-1]}}, instrReg[IMM_W-1:0]};
    assign branchOffset = immBranch << BR_SHIFT;

    assign id_valid   = validReg & ~stall & ~haltedReg;
    assign pc_sel     = id_valid & (isB | isBR) & condTrue(instrReg[11:9], flagsReg);
    assign pc_target  = isBR ? id_rdata1 : pcReg + branchOffset;
    assign halted     = haltedReg;
    assign id_opcode  = opcode;
    assign id_dst     = REG_AW'(instrReg[11:8]);
    assign id_pc_next = pcReg;

    always_comb begin
        case (opcode)
            OP_B, OP_BR:    id_imm = immBranch;
            OP_LLB, OP_LHB: id_imm = {{(DATA_W-8){1'b0}}, instrReg[7:0]};
            default:        id_imm = {{(DATA_W-4){instrReg[3]}}, instrReg[3:0]};
        endcase
    end

    // IF/ID: a taken branch squashes the wrong-path fetch; a halt freezes the stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            validReg <= 1'b0;
            instrReg <= '0;
            pcReg    <= '0;
        end else if (!haltedReg) begin
            if (pc_sel) begin
                validReg <= 1'b0;
            end else if (!stall) begin
                validReg <= if_valid;
                instrReg <= if_instr;
                pcReg    <= if_pc_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            haltedReg <= 1'b0;
        end else if (id_valid && opcode == OP_HLT) begin
            haltedReg <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flagsReg <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (flag_we[i]) flagsReg[i] <= flag_in[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 1; i < NUM_REGS; i++) begin
            if (!rst_n) begin
                regs[i] <= '0;
            end else if (wb_we && wb_dst == REG_AW'(i)) begin
                regs[i] <= wb_data;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed plus randomized bench for id_stage_pipelined, checked every cycle
// against an instruction-level model of the decode stage.
module tb_id_stage_pipelined;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc_next;
    logic        ex_valid;
    logic        ex_mem_read;
    logic        ex_sets_flags;
    logic [3:0]  ex_dst;
    logic [2:0]  flag_we;
    logic [2:0]  flag_in;
    logic        wb_we;
    logic [3:0]  wb_dst;
    logic [15:0] wb_data;
    logic        stall;
    logic        pc_sel;
    logic [15:0] pc_target;
    logic        halted;
    logic        id_valid;
    logic [3:0]  id_opcode;
    logic [3:0]  id_dst;
    logic [15:0] id_rdata1;
    logic [15:0] id_rdata2;
    logic [15:0] id_imm;
    logic [15:0] id_pc_next;

    always #5 clk = ~clk;

    id_stage_pipelined dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc_next   (if_pc_next),
        .ex_valid     (ex_valid),
        .ex_mem_read  (ex_mem_read),
        .ex_sets_flags(ex_sets_flags),
        .ex_dst       (ex_dst),
        .flag_we      (flag_we),
        .flag_in      (flag_in),
        .wb_we        (wb_we),
        .wb_dst       (wb_dst),
        .wb_data      (wb_data),
        .stall        (stall),
        .pc_sel       (pc_sel),
        .pc_target    (pc_target),
        .halted       (halted),
        .id_valid     (id_valid),
        .id_opcode    (id_opcode),
        .id_dst       (id_dst),
        .id_rdata1    (id_rdata1),
        .id_rdata2    (id_rdata2),
        .id_imm       (id_imm),
        .id_pc_next   (id_pc_next)
    );

    int checks   = 0;
    int failures = 0;

    // Reference state
    logic [15:0] mRegs [16];
    logic        mZ, mV, mN;
    logic        mValid, mHalt;
    logic [15:0] mInstr, mPc;
    logic        eStall, eIdValid, eTaken;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] readReg(input logic [3:0] a);
        if (a == 4'd0) return 16'h0000;
        if (wb_we && wb_dst == a) return wb_data;
        return mRegs[a];
    endfunction

    function automatic logic condOk(input logic [2:0] c);
        case (c)
            3'd0: return !mZ;
            3'd1: return mZ;
            3'd2: return !mZ && !mN;
            3'd3: return mN;
            3'd4: return mZ || !mN;
            3'd5: return mZ || mN;
            3'd6: return mV;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [15:0] sextBits(input logic [15:0] v, input int bits);
        int x;
        x = int'(v) & ((1 << bits) - 1);
        if (x >= (1 << (bits - 1))) x = x - (1 << bits);
        return 16'(x);
    endfunction

    task automatic modelReset();
        mValid = 0; mInstr = 0; mPc = 0; mHalt = 0;
        mZ = 0; mV = 0; mN = 0;
        for (int i = 0; i < 16; i++) mRegs[i] = 16'h0000;
    endtask

    // Compare every output against the model at the falling edge.
    task automatic look();
        logic [3:0]  op;
        logic [3:0]  srcs [$];
        logic        isBr, loadUse, compute;
        logic [15:0] target;
        int          off;
        @(negedge clk);
        op      = mInstr[15:12];
        compute = (op <= 4'd7);
        srcs.delete();
        if (compute)                       begin srcs.push_back(mInstr[7:4]); srcs.push_back(mInstr[3:0]); end
        if (op == OP_LW)                   srcs.push_back(mInstr[7:4]);
        if (op == OP_SW)                   begin srcs.push_back(mInstr[7:4]); srcs.push_back(mInstr[11:8]); end
        if (op == OP_LLB || op == OP_LHB)  srcs.push_back(mInstr[11:8]);
        if (op == OP_BR)                   srcs.push_back(mInstr[7:4]);
        loadUse = 0;
        if (ex_valid && ex_mem_read && ex_dst != 0)
            foreach (srcs[k]) if (srcs[k] == ex_dst) loadUse = 1;
        isBr     = (op == OP_B) || (op == OP_BR);
        eStall   = mValid && !mHalt && (loadUse || (isBr && ex_valid && ex_sets_flags));
        eIdValid = mValid && !mHalt && !eStall;
        eTaken   = eIdValid && isBr && condOk(mInstr[11:9]);

        chk("stall", 16'(stall), 16'(eStall));
        chk("id_valid", 16'(id_valid), 16'(eIdValid));
        chk("pc_sel", 16'(pc_sel), 16'(eTaken));
        chk("halted", 16'(halted), 16'(mHalt));
        if (eTaken) begin
            off    = int'(sextBits(mInstr, 9)) - ((mInstr[8]) ? 65536 : 0);
            target = (op == OP_BR) ? readReg(mInstr[7:4]) : 16'(int'(mPc) + off * 2);
            chk("pc_target", pc_target, target);
        end
        if (mValid) begin
            chk("id_opcode", 16'(id_opcode), 16'(op));
            chk("id_dst", 16'(id_dst), 16'(mInstr[11:8]));
            chk("id_pc_next", id_pc_next, mPc);
            if (compute || op == OP_LW || op == OP_SW || op == OP_BR)
                chk("id_rdata1", id_rdata1, readReg(mInstr[7:4]));
            if (op == OP_LLB || op == OP_LHB)
                chk("id_rdata1", id_rdata1, readReg(mInstr[11:8]));
            if (compute) chk("id_rdata2", id_rdata2, readReg(mInstr[3:0]));
            if (op == OP_SW) chk("id_rdata2", id_rdata2, readReg(mInstr[11:8]));
            if (isBr) chk("id_imm_br", id_imm, sextBits(mInstr, 9));
            if (op == OP_LLB || op == OP_LHB) chk("id_imm_llb", id_imm, {8'h00, mInstr[7:0]});
            if (op == OP_LW || op == OP_SW) chk("id_imm_mem", id_imm, sextBits(mInstr, 4));
        end
    endtask

    // Advance the model to the next edge, then step past it.
    task automatic tick();
        logic newHalt;
        if (!rst_n) begin
            modelReset();
        end else begin
            newHalt = mHalt || (eIdValid && mInstr[15:12] == OP_HLT);
            if (wb_we && wb_dst != 0) mRegs[wb_dst] = wb_data;
            if (flag_we[2]) mZ = flag_in[2];
            if (flag_we[1]) mV = flag_in[1];
            if (flag_we[0]) mN = flag_in[0];
            if (!mHalt) begin
                if (eTaken) mValid = 0;
                else if (!eStall) begin
                    mValid = if_valid; mInstr = if_instr; mPc = if_pc_next;
                end
            end
            mHalt = newHalt;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst_n = 1; if_valid = 0; if_instr = 0; if_pc_next = 0;
        ex_valid = 0; ex_mem_read = 0; ex_sets_flags = 0; ex_dst = 0;
        flag_we = 0; flag_in = 0; wb_we = 0; wb_dst = 0; wb_data = 0;
    endtask

    initial begin
        modelReset();
        idle();
        rst_n = 0;
        look();
        chk("reset_stall", 16'(stall), 16'h0);
        chk("reset_pc_sel", 16'(pc_sel), 16'h0);
        chk("reset_id_valid", 16'(id_valid), 16'h0);
        chk("reset_halted", 16'(halted), 16'h0);
        tick();
        rst_n = 1;

        // Write-through bypass and R0
        if_valid = 1; if_instr = 16'h0631; if_pc_next = 16'h0002;
        look(); tick();
        if_valid = 0; wb_we = 1; wb_dst = 3; wb_data = 16'h1234;
        look(); chk("r3_bypass", id_rdata1, 16'h1234); tick();
        wb_we = 0; if_valid = 1; if_instr = 16'h0601;
        look(); tick();
        if_valid = 0; wb_we = 1; wb_dst = 0; wb_data = 16'hFFFF;
        look(); chk("r0_reads_zero", id_rdata1, 16'h0000); tick();

        // Load-use: LW R5 in EX, ADD R6,R5,R1 in ID
        wb_we = 0; if_valid = 1; if_instr = 16'h0651; if_pc_next = 16'h0020;
        look(); tick();
        ex_valid = 1; ex_mem_read = 1; ex_dst = 5; if_instr = 16'h1234; if_pc_next = 16'h0022;
        look(); chk("lu_stall", 16'(stall), 16'h1); chk("lu_bubble", 16'(id_valid), 16'h0); tick();
        ex_valid = 0; ex_mem_read = 0;
        look(); chk("lu_release", 16'(id_valid), 16'h1); chk("lu_held_pc", id_pc_next, 16'h0020); tick();

        // Z=1, then B EQ -4 from pc_next 0x0010
        flag_we = 3'b100; flag_in = 3'b100; if_instr = 16'hC3FC; if_pc_next = 16'h0010;
        look(); tick();
        flag_we = 0; if_instr = 16'h0000; if_pc_next = 16'h0012;
        look(); chk("beq_taken", 16'(pc_sel), 16'h1); chk("beq_target", pc_target, 16'h0008); tick();
        if_instr = 16'hC3FC; if_pc_next = 16'h0010;
        look(); chk("flushed", 16'(id_valid), 16'h0); tick();

        // Flag-use stall, then Z cleared so EQ falls through
        ex_valid = 1; ex_sets_flags = 1; flag_we = 3'b100; flag_in = 3'b000; if_instr = 16'h0000;
        look(); chk("fu_stall", 16'(stall), 16'h1); chk("fu_no_sel", 16'(pc_sel), 16'h0); tick();
        ex_valid = 0; ex_sets_flags = 0; flag_we = 0;
        look(); chk("beq_not_taken", 16'(pc_sel), 16'h0); chk("fu_release", 16'(id_valid), 16'h1); tick();

        // HLT
        if_instr = 16'hF000; if_pc_next = 16'h0030;
        look(); tick();
        if_instr = 16'h0651;
        look(); chk("hlt_passes", 16'(id_valid), 16'h1); tick();
        if_instr = 16'h1111; ex_valid = 1; ex_mem_read = 1; ex_dst = 5;
        for (int i = 0; i < 3; i++) begin
            look(); chk("halted_sticky", 16'(halted), 16'h1); chk("halted_no_stall", 16'(stall), 16'h0); tick();
        end
        ex_valid = 0; ex_mem_read = 0; rst_n = 0;
        look(); tick();
        rst_n = 1;
        look(); chk("halt_cleared", 16'(halted), 16'h0); tick();

        // Reset in the middle of a load-use stall, with all flags set beforehand
        if_instr = 16'h0651; flag_we = 3'b111; flag_in = 3'b111;
        look(); tick();
        flag_we = 0; ex_valid = 1; ex_mem_read = 1; ex_dst = 5; rst_n = 0;
        look(); chk("stall_before_reset", 16'(stall), 16'h1); tick();
        rst_n = 1; if_instr = 16'hC200; if_pc_next = 16'h0040;
        look(); chk("rst_stall", 16'(stall), 16'h0); chk("rst_id_valid", 16'(id_valid), 16'h0); tick();
        ex_valid = 0; ex_mem_read = 0; if_valid = 0;
        look(); chk("rst_flags_eq", 16'(pc_sel), 16'h0); tick();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst_n         = mHalt ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 59) != 0);
            if_valid      = ($urandom_range(0, 3) != 0);
            if_instr      = 16'($urandom);
            if_pc_next    = 16'($urandom);
            ex_valid      = 1'($urandom);
            ex_mem_read   = 1'($urandom);
            ex_sets_flags = 1'($urandom);
            ex_dst        = 4'($urandom);
            flag_we       = 3'($urandom);
            flag_in       = 3'($urandom);
            wb_we         = 1'($urandom);
            wb_dst        = 4'($urandom);
            wb_data       = 16'($urandom);
            look();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
